// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: per-register write-pending bits, RAW/WAW/in-flight-limit stall, registered issue stage.
// Latency: 1 cycle from decoder accept to issue_valid_out; pending bit and in-flight count update at accept.
// Backpressure: dec_ready_out drops on hazard, flush, or a held issue slot that execute is not taking.
// Optional feature macro: WB_BYPASS_EN (same-cycle writeback clears the hazard for that register).
module issue_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_INFLIGHT   = 4,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      dec_valid_in,
  output logic                      dec_ready_out,
  input  logic                      read_a_in,
  input  logic [REG_ADDR_WIDTH-1:0] src_a_in,
  input  logic                      read_b_in,
  input  logic [REG_ADDR_WIDTH-1:0] src_b_in,
  input  logic                      write_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_in,
  output logic                      issue_valid_out,
  input  logic                      issue_ready_in,
  output logic [REG_ADDR_WIDTH-1:0] issue_dest_out,
  output logic                      issue_write_out,
  input  logic                      wb_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr_in,
  input  logic                      flush_in,
  output logic [CNT_WIDTH-1:0]      inflight_out,
  output logic                      wb_err_out
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0]       pending_q, pending_d;
  logic [NUM_REGS-1:0]       hz_pending;
  logic [NUM_REGS-1:0]       wb_onehot;
  logic [CNT_WIDTH-1:0]      inflight_q, inflight_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [REG_ADDR_WIDTH-1:0] issue_dest_q, issue_dest_d;
  logic                      issue_write_q, issue_write_d;
  logic                      wb_err_q, wb_err_d;

  logic wb_nz, dest_nz, hazard, stage_free, fire, set_en, clr_en;

  assign wb_nz   = wb_valid_in & (wb_addr_in != '0);
  assign dest_nz = dest_in != '0;

  // One-hot of the register being written back (r0 writebacks never match anything).
  always_comb begin
    wb_onehot = '0;
    if (wb_nz) wb_onehot[wb_addr_in] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  // A register completing writeback this cycle no longer blocks a dependent instruction.
  assign hz_pending = pending_q & ~wb_onehot;
`else
  assign hz_pending = pending_q;
`endif

  // r0 is never pending, so reads/writes of r0 fall out of the lookups naturally.
  assign hazard = (read_a_in & hz_pending[src_a_in])
                | (read_b_in & hz_pending[src_b_in])
                | (write_in  & hz_pending[dest_in])
                | (write_in  & dest_nz & (inflight_q == MAX_CNT));

  assign stage_free    = ~issue_valid_q | issue_ready_in;
  assign dec_ready_out = ~hazard & ~flush_in & stage_free;
  assign fire          = dec_valid_in & dec_ready_out;
  assign set_en        = fire & write_in & dest_nz;
  assign clr_en        = wb_nz & pending_q[wb_addr_in];

  // Pending bits and in-flight count: clear on writeback, set on accept; set applied last so it wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[wb_addr_in] = 1'b0;
    if (set_en) pending_d[dest_in] = 1'b1;
    pending_d[0] = 1'b0;
    inflight_d = inflight_q;
    case ({set_en, clr_en})
      2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase
    // Writeback to a register with nothing in flight is a protocol error; sticky until reset.
    wb_err_d = wb_err_q | (wb_nz & ~pending_q[wb_addr_in]);
  end

  // Issue output stage: load on accept, drain on handshake, drop on flush, otherwise hold.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_dest_d  = issue_dest_q;
    issue_write_d = issue_write_q;
    if (flush_in) begin
      issue_valid_d = 1'b0;
    end else if (fire) begin
      issue_valid_d = 1'b1;
      issue_dest_d  = dest_in;
      issue_write_d = write_in;
    end else if (issue_ready_in) begin
      issue_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_q     <= '0;
      inflight_q    <= '0;
      issue_valid_q <= 1'b0;
      issue_dest_q  <= '0;
      issue_write_q <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      inflight_q    <= inflight_d;
      issue_valid_q <= issue_valid_d;
      issue_dest_q  <= issue_dest_d;
      issue_write_q <= issue_write_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign issue_valid_out = issue_valid_q;
  assign issue_dest_out  = issue_dest_q;
  assign issue_write_out = issue_write_q;
  assign inflight_out    = inflight_q;
  assign wb_err_out      = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: per-cycle vector table plus hand sequences for stall/flush/reset corners.
// Issued instructions are predicted into a queue at accept and popped when execute takes them.
// Works in both WB_BYPASS_EN builds; only the writeback-cycle ready expectation differs.
module tb_issue_scoreboard;

  typedef struct {
    logic       dv; logic ra; logic [4:0] sa; logic rb; logic [4:0] sb;
    logic       wr; logic [4:0] d; logic ir; logic wbv; logic [4:0] wba; logic fl;
    logic       e_rdy; logic e_vld; logic [3:0] e_inf; logic e_err;
  } vec_t;

  typedef struct {
    logic [4:0] dest;
    logic       write;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       dec_valid_in, dec_ready_out;
  logic       read_a_in, read_b_in, write_in;
  logic [4:0] src_a_in, src_b_in, dest_in;
  logic       issue_valid_out, issue_ready_in, issue_write_out;
  logic [4:0] issue_dest_out;
  logic       wb_valid_in;
  logic [4:0] wb_addr_in;
  logic       flush_in;
  logic [3:0] inflight_out;
  logic       wb_err_out;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  always #5 clk_in = ~clk_in;

  issue_scoreboard dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .read_a_in(read_a_in), .src_a_in(src_a_in),
    .read_b_in(read_b_in), .src_b_in(src_b_in),
    .write_in(write_in), .dest_in(dest_in),
    .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in),
    .issue_dest_out(issue_dest_out), .issue_write_out(issue_write_out),
    .wb_valid_in(wb_valid_in), .wb_addr_in(wb_addr_in),
    .flush_in(flush_in), .inflight_out(inflight_out), .wb_err_out(wb_err_out)
  );

  function automatic vec_t mk(logic dv, logic ra, logic [4:0] sa, logic rb, logic [4:0] sb,
                              logic wr, logic [4:0] d, logic ir, logic wbv, logic [4:0] wba,
                              logic fl, logic e_rdy, logic e_vld, logic [3:0] e_inf, logic e_err);
    vec_t v;
    v.dv = dv; v.ra = ra; v.sa = sa; v.rb = rb; v.sb = sb;
    v.wr = wr; v.d = d; v.ir = ir; v.wbv = wbv; v.wba = wba; v.fl = fl;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_inf = e_inf; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dec_valid_in   = v.dv;
    read_a_in      = v.ra;  src_a_in = v.sa;
    read_b_in      = v.rb;  src_b_in = v.sb;
    write_in       = v.wr;  dest_in  = v.d;
    issue_ready_in = v.ir;
    wb_valid_in    = v.wbv; wb_addr_in = v.wba;
    flush_in       = v.fl;
  endtask

  // One clock: drive at posedge+1, check ready mid-cycle, check registered state at next posedge+1.
  task automatic cycle(input vec_t v, input string nm);
    exp_t e;
    drive(v);
    #2;
    chk({nm, " rdy"}, 32'(dec_ready_out), 32'(v.e_rdy));
    if (v.dv && v.e_rdy) begin
      e.dest = v.d; e.write = v.wr;
      exp_q.push_back(e);
    end
    @(posedge clk_in); #1;
    chk({nm, " vld"}, 32'(issue_valid_out), 32'(v.e_vld));
    chk({nm, " inf"}, 32'(inflight_out), 32'(v.e_inf));
    chk({nm, " err"}, 32'(wb_err_out), 32'(v.e_err));
  endtask

  // Execute side: every handshake must match the oldest accepted instruction; flush drops the held one.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1 && issue_valid_out === 1'b1) begin
      if (issue_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: issued dest %0d with nothing expected", issue_dest_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb dest", 32'(issue_dest_out), 32'(e.dest));
          chk("sb write", 32'(issue_write_out), 32'(e.write));
        end
      end else if (flush_in && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    vec_t v;
    logic bypass;
`ifdef WB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    rst_n_in = 1'b0;
    #2;
    chk("reset vld", 32'(issue_valid_out), 32'd0);
    chk("reset dest", 32'(issue_dest_out), 32'd0);
    chk("reset write", 32'(issue_write_out), 32'd0);
    chk("reset inf", 32'(inflight_out), 32'd0);
    chk("reset err", 32'(wb_err_out), 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    //                 dv ra sa rb sb wr d  ir wbv wba fl  rdy vld inf err
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,  1,  1,  1,  0)); // write r3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1,  0,  1,  0)); // drained
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0,  1,  0,  0,  0)); // wb r3
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  1,  1,  1,  0)); // write r1
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0,  1,  1,  2,  0)); // write r2
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,  1,  1,  3,  0)); // write r3
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0,  1,  1,  4,  0)); // write r4 -> full
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0,  0,  0,  4,  0)); // r5 stalls at limit
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 1, 2, 0,  0,  0,  3,  0)); // wb r2, still full this cycle
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0,  1,  1,  4,  0)); // r5 fires
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1,  0,  4,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0,  1,  1,  4,  0)); // write r0 ignored at limit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1,  0,  4,  0)); // wb r0 ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,  1,  0,  4,  1)); // wb r7 not pending
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1,  0,  4,  1)); // error sticky
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  4,  1)); // RAW on src_a r1
    tbl.push_back(mk(1, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0,  0,  0,  4,  1)); // RAW on src_b r4
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0,  1,  1,  4,  1)); // src r1 not read: no hazard
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0,  1,  0,  3,  1)); // drain r1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0,  1,  0,  2,  1)); // drain r3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0,  1,  0,  1,  1)); // drain r4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0,  1,  0,  0,  1)); // drain r5
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], $sformatf("row%0d", i));

    // Held output stage with execute stalled.
    cycle(mk(1,0,0,0,0,1,6,0,0,0,0, 1,1,1,1), "hold_a");
    chk("hold_a dest", 32'(issue_dest_out), 32'd6);
    cycle(mk(1,0,0,0,0,1,9,0,0,0,0, 0,1,1,1), "hold_b");
    chk("hold_b dest", 32'(issue_dest_out), 32'd6);
    chk("hold_b write", 32'(issue_write_out), 32'd1);
    cycle(mk(1,0,0,0,0,1,9,1,0,0,0, 1,1,2,1), "hold_c");
    chk("hold_c dest", 32'(issue_dest_out), 32'd9);
    cycle(mk(0,0,0,0,0,0,0,1,0,0,0, 1,0,2,1), "hold_d");
    cycle(mk(1,0,0,0,0,1,6,1,0,0,0, 0,0,2,1), "waw_r6");
    cycle(mk(0,0,0,0,0,0,0,1,1,6,0, 1,0,1,1), "wb_r6");
    cycle(mk(0,0,0,0,0,0,0,1,1,9,0, 1,0,0,1), "wb_r9");

    // RAW on r3 resolved by writeback; bypass lets it go in the writeback cycle.
    cycle(mk(1,0,0,0,0,1,3,1,0,0,0, 1,1,1,1), "raw_w3");
    cycle(mk(1,1,3,0,0,0,0,1,0,0,0, 0,0,1,1), "raw_s1");
    cycle(mk(1,1,3,0,0,0,0,1,0,0,0, 0,0,1,1), "raw_s2");
    cycle(mk(1,1,3,0,0,0,0,1,1,3,0, bypass,bypass,0,1), "raw_wb");
    cycle(mk(1,1,3,0,0,0,0,1,0,0,0, 1,1,0,1), "raw_go");
    cycle(mk(0,0,0,0,0,0,0,1,0,0,0, 1,0,0,1), "raw_idle");

    // Flush drops the held instruction but keeps r4 pending; reset mid-stall clears everything.
    cycle(mk(1,0,0,0,0,1,4,0,0,0,0, 1,1,1,1), "fl_w4");
    cycle(mk(1,0,0,0,0,0,0,0,0,0,1, 0,0,1,1), "fl_flush");
    cycle(mk(1,1,4,0,0,0,0,0,0,0,0, 0,0,1,1), "fl_raw4");
    cycle(mk(1,0,0,0,0,1,5,0,0,0,0, 1,1,2,1), "fl_w5");
    v = mk(1,1,4,0,0,0,0,0,0,0,0, 0,1,2,1);
    drive(v);
    #2;
    chk("stall rdy", 32'(dec_ready_out), 32'd0);
    rst_n_in = 1'b0;
    #1;
    exp_q.delete();
    chk("arst vld", 32'(issue_valid_out), 32'd0);
    chk("arst dest", 32'(issue_dest_out), 32'd0);
    chk("arst write", 32'(issue_write_out), 32'd0);
    chk("arst inf", 32'(inflight_out), 32'd0);
    chk("arst err", 32'(wb_err_out), 32'd0);
    @(posedge clk_in); #1;
    drive(mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0));
    rst_n_in = 1'b1;
    cycle(mk(1,1,4,0,0,0,0,1,0,0,0, 1,1,0,0), "post_rst");
    cycle(mk(0,0,0,0,0,0,0,1,0,0,0, 1,0,0,0), "post_idle");

    chk("queue empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
